ibus_fetch_ctrl: RTL and testbench

Instruction-bus controller between the fetch stage's program counter and the memory-side instruction bus. Accepts one fetch request at a time, drives the bus `valid`/`addr_ok`/`data_ok` handshake, extracts the 32-bit instruction from the 64-bit bus word and returns it as a one-cycle response. On a fetch redirect (jump or trap) it drains any in-flight bus transaction and discards its data, so stale instructions never reach fetch.

---
 rtl/ibus_fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_ibus_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_fetch_ctrl.sv
// rtl/ibus_fetch_ctrl.sv - instruction-bus fetch controller with flush drain
// Optional FETCH_REQ_BUFFER_EN: one-entry request buffer accepted while draining.
module ibus_fetch_ctrl #(
    parameter int ADDR_W = 64,
    parameter int BUS_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              resp_ok,
    output logic [31:0]       resp_data,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_err,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [BUS_W-1:0]  mem_data
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

    state_t            state;
    logic              stale;
    logic [ADDR_W-1:0] addr_q;
    logic              resp_ok_q;
    logic              accept;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic              complete;
    logic              drop;

`ifdef FETCH_REQ_BUFFER_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    assign req_ready = (state == S_IDLE) || (state == S_DRAIN && !buf_valid);
`else
    assign req_ready = (state == S_IDLE);
`endif

    assign accept   = req_valid & req_ready;
    assign complete = (state == S_ADDR && mem_addr_ok && mem_data_ok) ||
                      (state == S_DATA && mem_data_ok);
    // A flush landing on the completion cycle is as stale as an earlier one.
    assign drop     = stale | flush;
    assign resp_ok  = resp_ok_q & ~flush;

    always_comb begin
        issue      = 1'b0;
        issue_addr = req_addr;
        if (state == S_IDLE) begin
            issue = req_valid;
        end
`ifdef FETCH_REQ_BUFFER_EN
        else if (state == S_DRAIN && mem_data_ok) begin
            if (buf_valid && !flush) begin
                issue      = 1'b1;
                issue_addr = buf_addr;
            end else if (accept) begin
                issue = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            stale     <= 1'b0;
            addr_q    <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            resp_ok_q <= 1'b0;
            resp_data <= '0;
            resp_addr <= '0;
            resp_err  <= 1'b0;
`ifdef FETCH_REQ_BUFFER_EN
            buf_valid <= 1'b0;
            buf_addr  <= '0;
`endif
        end else begin
            resp_ok_q <= 1'b0;
            case (state)
                S_ADDR: begin
                    if (mem_addr_ok) begin
                        mem_valid <= 1'b0;
                        stale     <= 1'b0;
                        if (mem_data_ok)
                            state <= S_IDLE;
                        else if (drop)
                            state <= S_DRAIN;
                        else
                            state <= S_DATA;
                    end else if (flush) begin
                        stale <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (mem_data_ok)
                        state <= S_IDLE;
                    else if (flush)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (mem_data_ok)
                        state <= S_IDLE;
                end
                default: ;
            endcase

            if (complete && !drop) begin
                resp_ok_q <= 1'b1;
                resp_data <= addr_q[2] ? mem_data[63:32] : mem_data[31:0];
                resp_addr <= addr_q;
                resp_err  <= 1'b0;
            end

            if (issue) begin
                if (issue_addr[1:0] == 2'b00) begin
                    addr_q    <= issue_addr;
                    mem_valid <= 1'b1;
                    mem_addr  <= {issue_addr[ADDR_W-1:3], 3'b000};
                    stale     <= 1'b0;
                    state     <= S_ADDR;
                end else begin
                    resp_ok_q <= 1'b1;
                    resp_data <= '0;
                    resp_addr <= issue_addr;
                    resp_err  <= 1'b1;
                    state     <= S_IDLE;
                end
            end

`ifdef FETCH_REQ_BUFFER_EN
            if (state == S_DRAIN) begin
                if (mem_data_ok) begin
                    buf_valid <= 1'b0;
                end else if (accept) begin
                    buf_valid <= 1'b1;
                    buf_addr  <= req_addr;
                end else if (flush) begin
                    buf_valid <= 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ibus_fetch_ctrl.sv
// tb/tb_ibus_fetch_ctrl.sv - self-checking bench for ibus_fetch_ctrl
module tb_ibus_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        resp_ok;
    logic [31:0] resp_data;
    logic [63:0] resp_addr;
    logic        resp_err;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [63:0] mem_data;

    int n_vec = 0;
    int n_err = 0;

    ibus_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .flush(flush),
        .resp_ok(resp_ok), .resp_data(resp_data), .resp_addr(resp_addr), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [63:0] ra;
        logic        fl;
        logic        ao;
        logic        dok;
        logic [63:0] md;
        logic        e_rdy;
        logic        e_mv;
        logic [63:0] e_maddr;
        logic        e_rok;
        logic [31:0] e_rdata;
        logic [63:0] e_raddr;
        logic        e_rerr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rv, input logic [63:0] ra, input logic fl,
                        input logic ao, input logic dok, input logic [63:0] md);
        @(negedge clk);
        req_valid   = rv;
        req_addr    = ra;
        flush       = fl;
        mem_addr_ok = ao;
        mem_data_ok = dok;
        mem_data    = md;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic e_rdy, input logic e_mv,
                              input logic [63:0] e_maddr, input logic e_rok,
                              input logic [31:0] e_rdata, input logic [63:0] e_raddr,
                              input logic e_rerr);
        chk({tag, "/req_ready"}, 64'(req_ready), 64'(e_rdy));
        chk({tag, "/mem_valid"}, 64'(mem_valid), 64'(e_mv));
        if (e_mv) chk({tag, "/mem_addr"}, mem_addr, e_maddr);
        chk({tag, "/resp_ok"}, 64'(resp_ok), 64'(e_rok));
        if (e_rok) begin
            chk({tag, "/resp_data"}, 64'(resp_data), 64'(e_rdata));
            chk({tag, "/resp_addr"}, resp_addr, e_raddr);
            chk({tag, "/resp_err"}, 64'(resp_err), 64'(e_rerr));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "/req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "/mem_valid"}, 64'(mem_valid), 64'd0);
        chk({tag, "/mem_addr"}, mem_addr, 64'd0);
        chk({tag, "/resp_ok"}, 64'(resp_ok), 64'd0);
        chk({tag, "/resp_data"}, 64'(resp_data), 64'd0);
        chk({tag, "/resp_addr"}, resp_addr, 64'd0);
        chk({tag, "/resp_err"}, 64'(resp_err), 64'd0);
    endtask

    function automatic void add(input logic rv, input logic [63:0] ra, input logic fl,
                                input logic ao, input logic dok, input logic [63:0] md,
                                input logic e_rdy, input logic e_mv, input logic [63:0] e_maddr,
                                input logic e_rok, input logic [31:0] e_rdata,
                                input logic [63:0] e_raddr, input logic e_rerr);
        vec_t v;
        v.rv = rv; v.ra = ra; v.fl = fl; v.ao = ao; v.dok = dok; v.md = md;
        v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_maddr = e_maddr; v.e_rok = e_rok;
        v.e_rdata = e_rdata; v.e_raddr = e_raddr; v.e_rerr = e_rerr;
        tbl.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; req_valid = 0; req_addr = 0; flush = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_data = 0;
        repeat (2) @(negedge clk);
        #1 check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Cycle-by-cycle vectors starting from IDLE.
        add(1, 64'h8000_0004, 0, 0, 0, 64'h0,                   1, 0, 64'h0,         0, 32'h0,         64'h0,         0);
        add(0, 64'h0,         0, 1, 1, 64'h1111_2222_3333_4444, 0, 1, 64'h8000_0000, 0, 32'h0,         64'h0,         0);
        add(0, 64'h0,         0, 0, 0, 64'h0,                   1, 0, 64'h0,         1, 32'h1111_2222, 64'h8000_0004, 0);
        add(1, 64'h8000_0002, 0, 0, 0, 64'h0,                   1, 0, 64'h0,         0, 32'h0,         64'h0,         0);
        add(0, 64'h0,         0, 0, 0, 64'h0,                   1, 0, 64'h0,         1, 32'h0,         64'h8000_0002, 1);
        add(1, 64'h8000_0008, 1, 0, 0, 64'h0,                   1, 0, 64'h0,         0, 32'h0,         64'h0,         0);
        add(0, 64'h0,         0, 1, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 1, 64'h8000_0008, 0, 32'h0,         64'h0,         0);
        add(1, 64'h8000_000C, 0, 0, 0, 64'h0,                   1, 0, 64'h0,         1, 32'hCCCC_DDDD, 64'h8000_0008, 0);
        add(0, 64'h0,         0, 1, 1, 64'h5555_6666_7777_8888, 0, 1, 64'h8000_0008, 0, 32'h0,         64'h0,         0);
        add(1, 64'h8000_0010, 0, 0, 0, 64'h0,                   1, 0, 64'h0,         1, 32'h5555_6666, 64'h8000_000C, 0);
        add(0, 64'h0,         0, 1, 1, 64'h0123_4567_89AB_CDEF, 0, 1, 64'h8000_0010, 0, 32'h0,         64'h0,         0);
        add(0, 64'h0,         1, 0, 0, 64'h0,                   1, 0, 64'h0,         0, 32'h0,         64'h0,         0);
        add(0, 64'h0,         0, 0, 0, 64'h0,                   1, 0, 64'h0,         0, 32'h0,         64'h0,         0);
        foreach (tbl[i]) begin
            step(tbl[i].rv, tbl[i].ra, tbl[i].fl, tbl[i].ao, tbl[i].dok, tbl[i].md);
            expect_out($sformatf("tbl%0d", i), tbl[i].e_rdy, tbl[i].e_mv, tbl[i].e_maddr,
                       tbl[i].e_rok, tbl[i].e_rdata, tbl[i].e_raddr, tbl[i].e_rerr);
        end

        // Stalled addr_ok for 3 cycles, data 2 cycles after address acceptance.
        step(1, 64'h8000_0000, 0, 0, 0, 0);
        expect_out("stall/acc", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, (i == 3), 0, 0);
            expect_out($sformatf("stall/addr%0d", i), 0, 1, 64'h8000_0000, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0);
        expect_out("stall/wait", 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 64'hDEAD_BEEF_0BAD_F00D);
        expect_out("stall/data", 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        expect_out("stall/resp", 1, 0, 0, 1, 32'h0BAD_F00D, 64'h8000_0000, 0);
        step(0, 0, 0, 0, 0, 0);
        expect_out("stall/after", 1, 0, 0, 0, 0, 0, 0);

        // Flush in DATA, new request while the stale transaction drains.
        step(1, 64'h8000_0044, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        expect_out("drain/addr", 0, 1, 64'h8000_0040, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        expect_out("drain/flush", 0, 0, 0, 0, 0, 0, 0);
        begin
            logic taken;
            taken = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                step(!taken, 64'h8000_0100, 0, 0, (k == 4), 64'h7777_7777_7777_7777);
`ifdef FETCH_REQ_BUFFER_EN
                expect_out($sformatf("drain/k%0d", k), (k == 1), 0, 0, 0, 0, 0, 0);
                if (k == 1) taken = 1'b1;
`else
                expect_out($sformatf("drain/k%0d", k), 0, 0, 0, 0, 0, 0, 0);
`endif
            end
`ifndef FETCH_REQ_BUFFER_EN
            step(1, 64'h8000_0100, 0, 0, 0, 0);
            expect_out("drain/idle_acc", 1, 0, 0, 0, 0, 0, 0);
`endif
        end
        step(0, 0, 0, 1, 1, 64'h9999_0000_1234_5678);
        expect_out("drain/new_addr", 0, 1, 64'h8000_0100, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        expect_out("drain/new_resp", 1, 0, 0, 1, 32'h1234_5678, 64'h8000_0100, 0);

        // Asynchronous reset while in ADDR.
        step(1, 64'h8000_0024, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        expect_out("rst/addr", 0, 1, 64'h8000_0020, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1 check_reset_values("rst_in_addr");
        @(negedge clk);
        rst = 1'b0;

`ifndef FETCH_REQ_BUFFER_EN
        // Random traffic against a transaction-level reference model.
        begin
            bit          m_act, m_sent, m_want, m_pend, m_perr;
            logic [63:0] m_addr, m_raddr;
            logic [31:0] m_rdata;
            m_act = 0; m_sent = 0; m_want = 0; m_pend = 0; m_perr = 0;
            m_addr = 0; m_raddr = 0; m_rdata = 0;
            for (int c = 0; c < 3000; c++) begin
                bit          rv, fl, ao, dok;
                logic [63:0] ra, md;
                rv  = ($urandom_range(0, 1) == 1);
                ra  = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 4
                      + (($urandom_range(0, 4) == 0) ? 64'($urandom_range(1, 3)) : 64'd0);
                fl  = ($urandom_range(0, 6) == 0);
                ao  = m_act && !m_sent && ($urandom_range(0, 2) == 0);
                dok = m_act && (m_sent || ao) && ($urandom_range(0, 2) == 0);
                md  = {$urandom, $urandom};
                step(rv, ra, fl, ao, dok, md);
                expect_out($sformatf("rnd%0d", c), !m_act, m_act && !m_sent,
                           m_addr & ~64'h7, m_pend && !fl, m_rdata, m_raddr, m_perr);
                m_pend = 0;
                if (m_act) begin
                    if (fl) m_want = 0;
                    if (ao) m_sent = 1;
                    if (m_sent && dok) begin
                        m_act = 0;
                        if (m_want) begin
                            m_pend  = 1;
                            m_perr  = 0;
                            m_raddr = m_addr;
                            m_rdata = m_addr[2] ? md[63:32] : md[31:0];
                        end
                    end
                end else if (rv) begin
                    if (ra[1:0] != 2'b00) begin
                        m_pend  = 1;
                        m_perr  = 1;
                        m_rdata = 0;
                        m_raddr = ra;
                    end else begin
                        m_act  = 1;
                        m_sent = 0;
                        m_want = 1;
                        m_addr = ra;
                    end
                end
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
